// File: rtl/regfile_scoreboard_pkg.sv
// rtl/regfile_scoreboard_pkg.sv - shared constants, address-width helper and read-port bundle type
// for the register file scoreboard.
package regfile_pkg;

  localparam int DEFAULT_XLEN  = 32;
  localparam int DEFAULT_NREGS = 32;
  localparam int ZERO_REG      = 0;

  function automatic int calc_aw(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] data;
    logic                    busy;
  } rd_port_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - decode/write-back bus of the register file scoreboard.
// master = pipeline side, slave = register file.
interface regfile_scoreboard_if #(
  parameter int XLEN  = regfile_pkg::DEFAULT_XLEN,
  parameter int NREGS = regfile_pkg::DEFAULT_NREGS,
  parameter int NRD   = 2
);
  localparam int AW = regfile_pkg::calc_aw(NREGS);

  logic [NRD*AW-1:0]   rdAddr;
  logic [NRD*XLEN-1:0] rdData;
  logic [NRD-1:0]      rdBusy;
  logic                wbValid;
  logic [AW-1:0]       wbReg;
  logic [XLEN-1:0]     wbData;
  logic                issueValid;
  logic [AW-1:0]       issueReg;
  logic                flush;
  logic [AW:0]         busyCount;
  logic                anyBusy;

  modport master (
    output rdAddr, wbValid, wbReg, wbData, issueValid, issueReg, flush,
    input  rdData, rdBusy, busyCount, anyBusy
  );

  modport slave (
    input  rdAddr, wbValid, wbReg, wbData, issueValid, issueReg, flush,
    output rdData, rdBusy, busyCount, anyBusy
  );

endinterface

// File: rtl/regfile_scoreboard_read_port.sv
// rtl/regfile_scoreboard_read_port.sv - one combinational read port (data + busy).
// REGFILE_BYPASS_EN adds same-cycle write-back forwarding.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN  = DEFAULT_XLEN,
  parameter int NREGS = DEFAULT_NREGS,
  localparam int AW   = calc_aw(NREGS)
) (
  input  logic [AW-1:0]               addr_i,
  input  logic [NREGS-1:0][XLEN-1:0]  regs_i,
  input  logic [NREGS-1:0]            busy_i,
`ifdef REGFILE_BYPASS_EN
  input  logic                        wb_valid_i,
  input  logic [AW-1:0]               wb_reg_i,
  input  logic [XLEN-1:0]             wb_data_i,
  input  logic                        issue_valid_i,
  input  logic [AW-1:0]               issue_reg_i,
`endif
  output logic [XLEN-1:0]             data_o,
  output logic                        busy_o
);

  always_comb begin
    data_o = regs_i[addr_i];
    busy_o = busy_i[addr_i];
`ifdef REGFILE_BYPASS_EN
    // A forwarded value is already produced, so only a same-cycle re-issue keeps it busy.
    if (wb_valid_i && (wb_reg_i == addr_i) && (addr_i != AW'(ZERO_REG))) begin
      data_o = wb_data_i;
      busy_o = issue_valid_i && (issue_reg_i == addr_i);
    end
`endif
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - parametrised register file with per-register busy scoreboard.
// Optional REGFILE_BYPASS_EN forwards write-back data to same-cycle reads.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN  = DEFAULT_XLEN,
  parameter int NREGS = DEFAULT_NREGS,
  parameter int NRD   = 2,
  localparam int AW   = calc_aw(NREGS)
) (
  input  logic                 clock,
  input  logic                 reset,
  regfile_scoreboard_if.slave  bus
);

  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREGS-1:0]           busy_q, busy_d;
  logic [AW:0]                count_q, count_d;

  logic wb_en, issue_en, inc, dec;

  assign wb_en    = bus.wbValid && (bus.wbReg != AW'(ZERO_REG));
  assign issue_en = bus.issueValid && (bus.issueReg != AW'(ZERO_REG));

  always_comb begin
    regs_d  = regs_q;
    busy_d  = busy_q;
    count_d = count_q;
    inc     = 1'b0;
    dec     = 1'b0;

    if (wb_en) regs_d[bus.wbReg] = bus.wbData;

    if (bus.flush) begin
      busy_d = '0;
    end else if (wb_en) begin
      busy_d[bus.wbReg] = 1'b0;
    end
    if (issue_en) busy_d[bus.issueReg] = 1'b1;

    // Count only real transitions; a release on the register being re-issued is not one.
    inc = issue_en && !busy_q[bus.issueReg];
    dec = wb_en && busy_q[bus.wbReg] && !(issue_en && (bus.issueReg == bus.wbReg));

    if (bus.flush) begin
      count_d = {{AW{1'b0}}, issue_en};
    end else begin
      count_d = count_q + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      regs_q  <= '0;
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign bus.busyCount = count_q;
  assign bus.anyBusy   = (count_q != '0);

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_read_port #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
    ) u_rp (
      .addr_i        (bus.rdAddr[i*AW +: AW]),
      .regs_i        (regs_q),
      .busy_i        (busy_q),
`ifdef REGFILE_BYPASS_EN
      .wb_valid_i    (bus.wbValid),
      .wb_reg_i      (bus.wbReg),
      .wb_data_i     (bus.wbData),
      .issue_valid_i (bus.issueValid),
      .issue_reg_i   (bus.issueReg),
`endif
      .data_o        (bus.rdData[i*XLEN +: XLEN]),
      .busy_o        (bus.rdBusy[i])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - randomized self-checking bench for regfile_scoreboard
// against an array-based reference model; honours REGFILE_BYPASS_EN.
module tb_regfile_scoreboard;

  logic clock = 1'b0;
  logic reset = 1'b1;

  regfile_scoreboard_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus ();

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .NRD(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_regs [32];
  logic        m_busy [32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int popcount();
    int n = 0;
    for (int r = 0; r < 32; r++) if (m_busy[r]) n++;
    return n;
  endfunction

  task automatic drive(input bit wv, input logic [4:0] wr, input logic [31:0] wd,
                       input bit iv, input logic [4:0] ir, input bit fl);
    bus.wbValid    = wv;
    bus.wbReg      = wr;
    bus.wbData     = wd;
    bus.issueValid = iv;
    bus.issueReg   = ir;
    bus.flush      = fl;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    bus.rdAddr = {a1, a0};
  endtask

  task automatic check_outputs();
    for (int p = 0; p < 2; p++) begin
      logic [4:0]  a;
      logic [31:0] ed;
      logic        eb;
      a  = bus.rdAddr[p*5 +: 5];
      ed = m_regs[a];
      eb = m_busy[a];
`ifdef REGFILE_BYPASS_EN
      if (bus.wbValid && bus.wbReg == a && a != 0) begin
        ed = bus.wbData;
        eb = bus.issueValid && bus.issueReg == a;
      end
`endif
      chk($sformatf("rdData%0d[%0d]", p, a), 64'(bus.rdData[p*32 +: 32]), 64'(ed));
      chk($sformatf("rdBusy%0d[%0d]", p, a), 64'(bus.rdBusy[p]), 64'(eb));
    end
    chk("busyCount", 64'(bus.busyCount), 64'(popcount()));
    chk("anyBusy", 64'(bus.anyBusy), 64'(popcount() != 0));
  endtask

  task automatic model_step();
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      if (bus.wbValid && bus.wbReg != 0) m_regs[bus.wbReg] = bus.wbData;
      if (bus.flush) begin
        for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
      end else if (bus.wbValid && bus.wbReg != 0) begin
        m_busy[bus.wbReg] = 1'b0;
      end
      if (bus.issueValid && bus.issueReg != 0) m_busy[bus.issueReg] = 1'b1;
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic do_cycle();
    #1;
    check_outputs();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = 32'hxxxx_xxxx;
      m_busy[r] = 1'bx;
    end
    idle();
    set_rd(0, 0);
    @(negedge clock);
    @(posedge clock);
    model_step();
    @(negedge clock);
    reset = 1'b0;

    // Reset state across every address
    for (int a = 0; a < 32; a++) begin
      set_rd(5'(a), 5'(31 - a));
      do_cycle();
    end
    #1 chk("reset_cnt", 64'(bus.busyCount), 64'd0);

    // Plain write, then ignored write to x0
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
    do_cycle();
    idle();
    set_rd(5, 0);
    #1 chk("wb5", 64'(bus.rdData[31:0]), 64'hDEADBEEF);
    do_cycle();
    drive(1, 0, 32'h1234, 0, 0, 0);
    do_cycle();
    idle();
    #1 chk("x0", 64'(bus.rdData[63:32]), 64'd0);
    do_cycle();

    // Issue 3, 7, 3
    drive(0, 0, 0, 1, 3, 0); do_cycle();
    #1 chk("cnt_i3", 64'(bus.busyCount), 64'd1);
    drive(0, 0, 0, 1, 7, 0); do_cycle();
    #1 chk("cnt_i7", 64'(bus.busyCount), 64'd2);
    drive(0, 0, 0, 1, 3, 0); do_cycle();
    #1 chk("cnt_i3b", 64'(bus.busyCount), 64'd2);
    drive(1, 7, 32'h77, 0, 0, 0); do_cycle();
    idle();
    set_rd(7, 3);
    #1 chk("cnt_wb7", 64'(bus.busyCount), 64'd1);
    chk("busy7", 64'(bus.rdBusy[0]), 64'd0);
    do_cycle();
    drive(1, 3, 32'h55, 1, 3, 0); do_cycle();
    idle();
    set_rd(3, 7);
    #1 chk("data3", 64'(bus.rdData[31:0]), 64'h55);
    chk("busy3", 64'(bus.rdBusy[0]), 64'd1);
    do_cycle();

    // Flush with simultaneous issue
    drive(0, 0, 0, 1, 1, 0); do_cycle();
    drive(0, 0, 0, 1, 2, 0); do_cycle();
    drive(0, 0, 0, 1, 4, 0); do_cycle();
    drive(0, 0, 0, 1, 9, 1); do_cycle();
    idle();
    set_rd(9, 3);
    #1 chk("flush_cnt", 64'(bus.busyCount), 64'd1);
    chk("flush_b9", 64'(bus.rdBusy[0]), 64'd1);
    chk("flush_b3", 64'(bus.rdBusy[1]), 64'd0);
    do_cycle();

    // Same-cycle write and read of reg 10
    drive(1, 10, 32'hA5A5A5A5, 0, 0, 0);
    set_rd(0, 10);
`ifdef REGFILE_BYPASS_EN
    #1 chk("bypass10", 64'(bus.rdData[63:32]), 64'hA5A5A5A5);
`else
    #1 chk("nobypass10", 64'(bus.rdData[63:32]), 64'd0);
`endif
    do_cycle();

    // Reset wins over write and issue
    drive(1, 6, 32'h66, 1, 6, 0);
    reset = 1'b1;
    set_rd(6, 6);
    @(posedge clock);
    model_step();
    @(negedge clock);
    reset = 1'b0;
    idle();
    #1 chk("rst_r6", 64'(bus.rdData[31:0]), 64'd0);
    chk("rst_b6", 64'(bus.rdBusy[0]), 64'd0);
    chk("rst_cnt", 64'(bus.busyCount), 64'd0);
    do_cycle();

    // Randomized traffic; narrow register range on some cycles to force collisions
    for (int n = 0; n < 600; n++) begin
      bit          narrow;
      logic [4:0]  wr, ir;
      narrow = ($urandom_range(0, 3) == 0);
      wr = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      ir = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      drive($urandom_range(0, 1) == 1, wr, $urandom,
            $urandom_range(0, 1) == 1, ir, $urandom_range(0, 19) == 0);
      set_rd(($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31)),
             ($urandom_range(0, 2) == 0) ? ir : 5'($urandom_range(0, 31)));
      reset = ($urandom_range(0, 99) == 0);
      do_cycle();
    end
    reset = 1'b0;
    idle();
    do_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor of the processor's integer register file.
- Configurable data width, register count and read-port count; synchronous clocked write-back.
- Adds a per-register busy scoreboard so the pipeline can stall on pending producers.
- Sits between decode (reads, issue) and write-back (writes, busy release); x0 is hardwired to zero.

Parameters:
- XLEN, 32, data width of each register
- NREGS, 32, number of architectural registers (power of two, >= 2)
- NRD, 2, number of independent read ports
- AW, $clog2(NREGS), address width (derived localparam, not overridable)

Ports:
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- rdAddr  in  NRD*AW  packed read addresses; port i = bits [i*AW +: AW]
- rdData  out  NRD*XLEN  packed read data, combinational from rdAddr
- rdBusy  out  NRD  busy bit of each addressed register, combinational
- wbValid  in  1  write-back strobe
- wbReg  in  AW  write-back destination
- wbData  in  XLEN  write-back data
- issueValid  in  1  instruction issued with destination issueReg
- issueReg  in  AW  destination being claimed
- flush  in  1  pipeline flush; releases all busy bits
- busyCount  out  AW+1  number of registers currently busy
- anyBusy  out  1  busyCount != 0

Behaviour:
- Reset (synchronous, active-high) clears all registers, all busy bits and busyCount to 0 on the next rising edge. Reset overrides wbValid, issueValid and flush in the same cycle. Mid-operation reset discards pending writes.
- Reads are combinational with zero latency. Reading address 0 always returns 0 with rdBusy = 0.
- Write: at a rising edge with wbValid=1 and wbReg!=0, registers[wbReg] <= wbData. Writes to 0 are ignored. Write latency is one edge; a same-cycle read returns the old value (see optional feature).
- Busy set: issueValid=1 and issueReg!=0 sets busy[issueReg] at the edge.
- Busy clear: wbValid=1 and wbReg!=0 clears busy[wbReg] at the edge.
- Issue and write-back to the same register in the same cycle: the data is written and busy stays/becomes 1, because the new producer wins.
- Issue to an already-busy register: busy stays 1 and busyCount is unchanged.
- Write-back to a non-busy register: the data is written and busyCount is unchanged; there is no underflow.
- Flush: clears every busy bit. If issueValid is set in the same cycle, busy[issueReg] ends as 1 and busyCount = 1. A write-back in a flush cycle still updates data.
- busyCount is a registered counter, updated as +1 / -1 / 0 / reload per the rules above. It must always equal the popcount of the busy vector and never exceeds NREGS-1.
- All outputs are registered-state-derived except rdData/rdBusy, which are combinational muxes of state (plus bypass, when enabled).

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: a read port whose rdAddr equals wbReg (nonzero) while wbValid=1 returns wbData combinationally in that cycle, and its rdBusy reads 0 unless issueValid targets the same register.
- Undefined: reads return stored state only; a same-cycle write is visible from the next cycle.

Decomposition:
- Shared package regfile_pkg holds:
  - default XLEN/NREGS constants
  - the ZERO_REG address constant
  - the function deriving AW
  - a typedef for the packed read-port bundle
- One natural sub-module, regfile_read_port: one address-to-data/busy mux, with the bypass compare under REGFILE_BYPASS_EN. It is instantiated NRD times via generate.

Test Plan:
- Reset then read all 32 addresses -> every rdData=0, rdBusy=0, busyCount=0, anyBusy=0.
- wbValid, wbReg=5, wbData=0xDEADBEEF; next cycle rdAddr0=5 -> rdData0=0xDEADBEEF. Then a write to reg 0 with 0x1234 -> rdAddr=0 reads 0.
- Issue regs 3, 7, 3 on consecutive cycles -> busyCount 1, 2, 2. Write-back reg 7 -> busyCount=1, rdBusy for 7 = 0. Same cycle issue+wb reg 3 with 0x55 -> busy[3]=1, data=0x55.
- Busy regs 1, 2, 4, then flush with issueReg=9 -> busyCount=1, only busy[9]=1.
- Same-cycle wbReg=10, wbData=0xA5A5A5A5 with rdAddr1=10 -> with REGFILE_BYPASS_EN returns 0xA5A5A5A5, without it returns the old value.
- Reset asserted in the same cycle as a write to reg 6 with issue of reg 6 -> reg 6 reads 0, busy[6]=0, busyCount=0.
